// File: rtl/mem_dma_copy_pkg.sv
// Shared widths, FSM state encoding and command type for the block-copy DMA.
package mem_dma_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int LEN_W  = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] src;
      logic [ADDR_W-1:0] dst;
      logic [LEN_W-1:0]  len;
   } copy_cmd_t;

endpackage

// File: rtl/mem_dma_copy_if.sv
// Main-memory word port: the DMA drives address/strobes/write data, memory returns read data.
interface mem_dma_copy_if
   import mem_dma_pkg::*;
#(
   parameter int AW = mem_dma_pkg::ADDR_W,
   parameter int DW = mem_dma_pkg::DATA_W
);

   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic          mem_wr;
   logic [DW-1:0] mem_w_data;
   logic [DW-1:0] mem_r_data;

   modport master (
      output mem_addr, mem_rd, mem_wr, mem_w_data,
      input  mem_r_data
   );

   modport slave (
      input  mem_addr, mem_rd, mem_wr, mem_w_data,
      output mem_r_data
   );

endinterface

// File: rtl/mem_dma_copy.sv
// Word-at-a-time block copy master: one read cycle then one write cycle per word.
// Optional MEM_DMA_BACKWARD_EN copies descending when dst > src for memmove-safe overlap.
module mem_dma_copy
   import mem_dma_pkg::*;
#(
   parameter int ADDR_W = mem_dma_pkg::ADDR_W,
   parameter int DATA_W = mem_dma_pkg::DATA_W,
   parameter int LEN_W  = mem_dma_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] src_addr_i,
   input  logic [ADDR_W-1:0] dst_addr_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              done_o,
   mem_dma_copy_if.master    mem
);

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  src_q, src_d;
   logic [ADDR_W-1:0]  dst_q, dst_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [DATA_W-1:0]  buf_q, buf_d;
   logic [ADDR_W-1:0]  step;

`ifdef MEM_DMA_BACKWARD_EN
   logic               dec_q, dec_d;
   logic [ADDR_W-1:0]  len_lo;

   assign len_lo = len_i[ADDR_W-1:0];
   // Adding all-ones is a modulo-2^ADDR_W decrement.
   assign step   = dec_q ? '1 : ADDR_W'(1);
`else
   assign step   = ADDR_W'(1);
`endif

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      buf_d   = buf_q;
`ifdef MEM_DMA_BACKWARD_EN
      dec_d   = dec_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = READ;
                  src_d   = src_addr_i;
                  dst_d   = dst_addr_i;
                  rem_d   = len_i;
`ifdef MEM_DMA_BACKWARD_EN
                  dec_d   = (dst_addr_i > src_addr_i);
                  if (dst_addr_i > src_addr_i) begin
                     src_d = src_addr_i + len_lo - ADDR_W'(1);
                     dst_d = dst_addr_i + len_lo - ADDR_W'(1);
                  end
`endif
               end
            end
         end
         READ: begin
            if (abort_i) begin
               state_d = IDLE;
            end else begin
               buf_d   = mem.mem_r_data;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (abort_i) begin
               state_d = IDLE;
            end else begin
               src_d   = src_q + step;
               dst_d   = dst_q + step;
               rem_d   = rem_q - LEN_W'(1);
               state_d = (rem_q == LEN_W'(1)) ? DONE : READ;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         buf_q   <= '0;
`ifdef MEM_DMA_BACKWARD_EN
         dec_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         buf_q   <= buf_d;
`ifdef MEM_DMA_BACKWARD_EN
         dec_q   <= dec_d;
`endif
      end
   end

   // Every output is a decode of registered state only.
   assign busy_o         = (state_q != IDLE);
   assign done_o         = (state_q == DONE);
   assign mem.mem_rd     = (state_q == READ);
   assign mem.mem_wr     = (state_q == WRITE);
   assign mem.mem_addr   = (state_q == READ)  ? src_q :
                           (state_q == WRITE) ? dst_q : '0;
   assign mem.mem_w_data = (state_q == WRITE) ? buf_q : '0;

endmodule

// File: tb/tb_mem_dma_copy.sv
// Directed bench for mem_dma_copy with a 256x16 memory model behind the port.
module tb_mem_dma_copy;
   import mem_dma_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic [7:0]  src_addr_i;
   logic [7:0]  dst_addr_i;
   logic [8:0]  len_i;
   logic        abort_i;
   logic        busy_o;
   logic        done_o;

   mem_dma_copy_if mem_bus ();

   mem_dma_copy dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .src_addr_i (src_addr_i),
      .dst_addr_i (dst_addr_i),
      .len_i      (len_i),
      .abort_i    (abort_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .mem        (mem_bus.master)
   );

   logic [15:0] tb_mem [256];

   assign mem_bus.mem_r_data = tb_mem[mem_bus.mem_addr];

   always @(posedge clk) begin
      if (mem_bus.mem_wr) tb_mem[mem_bus.mem_addr] <= mem_bus.mem_w_data;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] rd_log [32];
   logic [7:0] wr_log [32];
   int done_cyc, done_cnt, rd_cnt, wr_cnt, both_cnt, alt_err, busy_err;

   // Launches one command and records what the port does for 2*len+6 cycles.
   task automatic run_copy(input logic [7:0] src, input logic [7:0] dst, input logic [8:0] len);
      int n;
      n = int'(len);
      @(negedge clk);
      start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = len;
      @(posedge clk);
      #1 start_i = 1'b0;
      done_cyc = 0; done_cnt = 0; rd_cnt = 0; wr_cnt = 0;
      both_cnt = 0; alt_err = 0; busy_err = 0;
      for (int c = 1; c <= 2 * n + 6; c++) begin
         @(negedge clk);
         if (mem_bus.mem_rd) begin
            if (rd_cnt < 32) rd_log[rd_cnt] = mem_bus.mem_addr;
            rd_cnt++;
         end
         if (mem_bus.mem_wr) begin
            if (wr_cnt < 32) wr_log[wr_cnt] = mem_bus.mem_addr;
            wr_cnt++;
         end
         if (mem_bus.mem_rd && mem_bus.mem_wr) both_cnt++;
         if (c <= 2 * n && (mem_bus.mem_rd !== (c % 2 == 1) || mem_bus.mem_wr !== (c % 2 == 0)))
            alt_err++;
         if (done_o) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (c <= 2 * n + 1 && !busy_o) busy_err++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
      src_addr_i = '0; dst_addr_i = '0; len_i = '0;
      for (int i = 0; i < 256; i++) tb_mem[i] <= 16'h0000;
      #12;
      total++;
      if ({busy_o, done_o, mem_bus.mem_rd, mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_w_data} !== 28'h0) begin
         bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b addr=%h wd=%h, want all zero",
                  busy_o, done_o, mem_bus.mem_rd, mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_w_data);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({busy_o, done_o, mem_bus.mem_rd, mem_bus.mem_wr} !== 4'b0000) begin
         bad++;
         $display("FAIL idle_after_reset: got busy=%b done=%b rd=%b wr=%b, want 0000",
                  busy_o, done_o, mem_bus.mem_rd, mem_bus.mem_wr);
      end
      $display("reset: released, block idle");
   endtask

   task automatic test_basic_copy();
      for (int i = 0; i < 4; i++) begin
         tb_mem[8'h10 + i] <= 16'hA000 + 16'(i);
         tb_mem[8'h80 + i] <= 16'h0000;
      end
      run_copy(8'h10, 8'h80, 9'd4);
      total++;
      if (done_cyc !== 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", done_cyc); end
      total++;
      if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
      total++;
      if (rd_cnt !== 4 || wr_cnt !== 4) begin
         bad++; $display("FAIL basic_access_count: got rd=%0d wr=%0d want 4/4", rd_cnt, wr_cnt);
      end
      total++;
      if (both_cnt !== 0 || alt_err !== 0) begin
         bad++; $display("FAIL basic_alternation: got overlap=%0d misorder=%0d want 0/0", both_cnt, alt_err);
      end
      total++;
      if (busy_err !== 0) begin bad++; $display("FAIL basic_busy: got %0d low cycles want 0", busy_err); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (tb_mem[8'h80 + i] !== 16'hA000 + 16'(i)) begin
            bad++;
            $display("FAIL basic_data[%0d]: got %h want %h", i, tb_mem[8'h80 + i], 16'hA000 + 16'(i));
         end
      end
      $display("basic_copy: src=10 dst=80 len=4 done_cycle=%0d", done_cyc);
   endtask

   task automatic test_zero_len();
      run_copy(8'h33, 8'h44, 9'd0);
      total++;
      if (done_cyc !== 1 || done_cnt !== 1) begin
         bad++; $display("FAIL zero_len_done: got cycle=%0d pulses=%0d want 1/1", done_cyc, done_cnt);
      end
      total++;
      if (rd_cnt !== 0 || wr_cnt !== 0) begin
         bad++; $display("FAIL zero_len_access: got rd=%0d wr=%0d want 0/0", rd_cnt, wr_cnt);
      end
      $display("zero_len: done_cycle=%0d", done_cyc);
   endtask

   task automatic test_wrap();
      logic [7:0] exp_rd [3];
      logic [15:0] exp_d [3];
      exp_rd[0] = 8'hFE; exp_rd[1] = 8'hFF; exp_rd[2] = 8'h00;
      exp_d[0] = 16'hC0FE; exp_d[1] = 16'hC0FF; exp_d[2] = 16'hC000;
      for (int i = 0; i < 3; i++) begin
         tb_mem[exp_rd[i]] <= exp_d[i];
         tb_mem[8'h01 + i] <= 16'h0000;
      end
      run_copy(8'hFE, 8'h01, 9'd3);
      total++;
      if (done_cyc !== 7) begin bad++; $display("FAIL wrap_latency: got %0d want 7", done_cyc); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rd_log[i] !== exp_rd[i] || wr_log[i] !== 8'(8'h01 + i)) begin
            bad++;
            $display("FAIL wrap_addr[%0d]: got rd=%h wr=%h want rd=%h wr=%h",
                     i, rd_log[i], wr_log[i], exp_rd[i], 8'(8'h01 + i));
         end
         total++;
         if (tb_mem[8'h01 + i] !== exp_d[i]) begin
            bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, tb_mem[8'h01 + i], exp_d[i]);
         end
      end
      $display("wrap: src=FE dst=01 len=3 done_cycle=%0d", done_cyc);
   endtask

   task automatic test_abort();
      int wr_seen, done_seen, busy_late;
      for (int i = 0; i < 5; i++) begin
         tb_mem[8'h90 + i] <= 16'h5000 + 16'(i);
         tb_mem[8'h40 + i] <= 16'hDEAD;
      end
      tb_mem[8'hC0] <= 16'hBEEF;
      wr_seen = 0; done_seen = 0; busy_late = 0;
      @(negedge clk);
      start_i = 1'b1; src_addr_i = 8'h90; dst_addr_i = 8'h40; len_i = 9'd5;
      @(posedge clk);
      #1 start_i = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_bus.mem_wr) wr_seen++;
         if (done_o) done_seen++;
         if (c >= 5 && busy_o) busy_late++;
         start_i = (c == 2);
         if (c == 2) begin dst_addr_i = 8'hC0; len_i = 9'd1; end
         abort_i = (c == 4);
      end
      start_i = 1'b0; abort_i = 1'b0;
      total++;
      if (wr_seen !== 2) begin bad++; $display("FAIL abort_writes: got %0d want 2", wr_seen); end
      total++;
      if (done_seen !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
      total++;
      if (busy_late !== 0) begin bad++; $display("FAIL abort_busy: got %0d busy cycles want 0", busy_late); end
      total++;
      if (tb_mem[8'h40] !== 16'h5000 || tb_mem[8'h41] !== 16'h5001 || tb_mem[8'h42] !== 16'hDEAD) begin
         bad++;
         $display("FAIL abort_data: got %h %h %h want 5000 5001 dead",
                  tb_mem[8'h40], tb_mem[8'h41], tb_mem[8'h42]);
      end
      total++;
      if (tb_mem[8'hC0] !== 16'hBEEF) begin
         bad++; $display("FAIL busy_start_ignored: got %h want beef", tb_mem[8'hC0]);
      end
      $display("abort: writes=%0d done=%0d", wr_seen, done_seen);
   endtask

   task automatic test_overlap();
      logic [15:0] exp_d [3];
`ifdef MEM_DMA_BACKWARD_EN
      exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333;
`else
      exp_d[0] = 16'h1111; exp_d[1] = 16'h1111; exp_d[2] = 16'h1111;
`endif
      tb_mem[8'h20] <= 16'h1111; tb_mem[8'h21] <= 16'h2222;
      tb_mem[8'h22] <= 16'h3333; tb_mem[8'h23] <= 16'h4444;
      run_copy(8'h20, 8'h21, 9'd3);
      total++;
      if (done_cyc !== 7) begin bad++; $display("FAIL overlap_latency: got %0d want 7", done_cyc); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (tb_mem[8'h21 + i] !== exp_d[i]) begin
            bad++; $display("FAIL overlap_data[%0d]: got %h want %h", i, tb_mem[8'h21 + i], exp_d[i]);
         end
      end
      $display("overlap: src=20 dst=21 len=3 -> %h %h %h", tb_mem[8'h21], tb_mem[8'h22], tb_mem[8'h23]);
   endtask

   task automatic test_async_reset();
      tb_mem[8'h60] <= 16'h7777; tb_mem[8'h61] <= 16'h7778; tb_mem[8'h68] <= 16'h0000;
      @(negedge clk);
      start_i = 1'b1; src_addr_i = 8'h60; dst_addr_i = 8'h68; len_i = 9'd2;
      @(posedge clk);
      #1 start_i = 1'b0;
      #2;
      total++;
      if (mem_bus.mem_rd !== 1'b1) begin bad++; $display("FAIL async_pre_read: got rd=%b want 1", mem_bus.mem_rd); end
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy_o, done_o, mem_bus.mem_rd, mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_w_data} !== 28'h0) begin
         bad++;
         $display("FAIL async_reset_outputs: got busy=%b done=%b rd=%b wr=%b addr=%h wd=%h, want all zero",
                  busy_o, done_o, mem_bus.mem_rd, mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_w_data);
      end
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      total++;
      if (tb_mem[8'h68] !== 16'h0000) begin
         bad++; $display("FAIL async_no_write: got %h want 0000", tb_mem[8'h68]);
      end
      run_copy(8'h60, 8'h68, 9'd1);
      total++;
      if (done_cyc !== 3 || tb_mem[8'h68] !== 16'h7777) begin
         bad++; $display("FAIL async_restart: got cycle=%0d data=%h want 3/7777", done_cyc, tb_mem[8'h68]);
      end
      $display("async_reset: restart done_cycle=%0d", done_cyc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_copy();
      test_zero_len();
      test_wrap();
      test_abort();
      test_overlap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
